// File: rtl/tank_link_pkg.sv
// Shared definitions for the inter-board tank position link.
// Used by the transmitter (tank_pos_tx / uart_tx_byte) and by the peer's
// receiver, so packet layout and checksum stay identical on both ends.
package tank_link_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         PKT_BYTES = 5;
   localparam logic [2:0] LAST_BYTE = 3'(PKT_BYTES - 1);

   // Bit-level sequencing inside one 8N1 byte.
   typedef enum logic [1:0] {
      BIT_IDLE,
      BIT_START,
      BIT_DATA,
      BIT_STOP
   } bit_state_t;

   // Packet-level sequencing across the five bytes.
   typedef enum logic [1:0] {
      PKT_IDLE,
      PKT_SEND,
      PKT_DONE
   } pkt_state_t;

   // Byte 3: select flag plus the two high bits of each coordinate.
   function automatic logic [7:0] pkt_flags(input logic       sel,
                                            input logic [1:0] x_hi,
                                            input logic [1:0] y_hi);
      return {sel, 1'b0, x_hi, y_hi, 2'b00};
   endfunction

   function automatic logic [7:0] pkt_checksum(input logic [7:0] b1,
                                               input logic [7:0] b2,
                                               input logic [7:0] b3);
      return b1 ^ b2 ^ b3;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - load tx_byte and begin a frame; honoured when idle or in
//                  the final cycle of a stop bit (back-to-back bytes, no gap)
//   tx_byte      - byte to send, sampled on the start cycle
//   tx           - serial line, registered, idle high
//   done         - high during the final cycle of the stop bit
module uart_tx_byte
   import tank_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 564
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       tx,
   output logic       done
);

   localparam int            BW       = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   bit_state_t    state, state_n;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          baud_end;
   logic          load;

   assign baud_end = (baud == BAUD_MAX);
   assign done     = (state == BIT_STOP) && baud_end;
   // Accepting start at the end of a stop bit keeps bytes contiguous.
   assign load     = start && ((state == BIT_IDLE) || done);

   always_comb begin
      state_n = state;
      case (state)
         BIT_IDLE:  if (start) state_n = BIT_START;
         BIT_START: if (baud_end) state_n = BIT_DATA;
         BIT_DATA:  if (baud_end && bit_idx == 3'd7) state_n = BIT_STOP;
         BIT_STOP:  if (baud_end) state_n = start ? BIT_START : BIT_IDLE;
         default:   state_n = BIT_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= BIT_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         state <= state_n;
         if (load) begin
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= tx_byte;
            tx      <= 1'b0;
         end else if (state != BIT_IDLE) begin
            if (baud_end) begin
               baud <= '0;
               case (state)
                  BIT_START: tx <= shreg[0];
                  BIT_DATA: begin
                     if (bit_idx == 3'd7) begin
                        tx <= 1'b1;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                     end
                  end
                  default: tx <= 1'b1;
               endcase
            end else begin
               baud <= baud + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tank_pos_tx.sv
// Sends the local tank position/select as a 5-byte UART packet on each
// rising edge of vsync: A5, X[7:0], Y[7:0], flags, checksum.
// Ports:
//   clk, rst     - pixel clock, synchronous active-high reset
//   vsync        - frame sync; rising edge while idle starts a packet
//   xpos, ypos   - 10-bit tank position, snapshotted at the trigger
//   select       - select-mode flag, snapshotted at the trigger
//   tx           - 8N1 serial line, idle high
//   busy         - packet in flight (through the done cycle)
//   packet_done  - one-cycle pulse after the last stop bit
module tank_pos_tx
   import tank_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 564
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic [9:0] xpos,
   input  logic [9:0] ypos,
   input  logic       select,
   output logic       tx,
   output logic       busy,
   output logic       packet_done
);

   pkt_state_t state, state_n;
   logic       vsync_q;
   logic [9:0] x_q, y_q;
   logic       sel_q;
   logic [2:0] byte_idx;
   logic [2:0] sel_idx;
   logic [7:0] cur_byte;
   logic       byte_done;
   logic       trigger;
   logic       send_next;
   logic       start;

   assign busy        = (state != PKT_IDLE);
   assign packet_done = (state == PKT_DONE);
   assign trigger     = vsync && !vsync_q && !busy;
   assign send_next   = (state == PKT_SEND) && byte_done && (byte_idx != LAST_BYTE);
   assign start       = trigger || send_next;
   // Byte 0 is constant, so the unregistered snapshot on the trigger cycle
   // does not matter.
   assign sel_idx     = trigger ? 3'd0 : byte_idx + 3'd1;

   always_comb begin
      cur_byte = SYNC_BYTE;
      case (sel_idx)
         3'd1:    cur_byte = x_q[7:0];
         3'd2:    cur_byte = y_q[7:0];
         3'd3:    cur_byte = pkt_flags(sel_q, x_q[9:8], y_q[9:8]);
         3'd4:    cur_byte = pkt_checksum(x_q[7:0], y_q[7:0],
                                          pkt_flags(sel_q, x_q[9:8], y_q[9:8]));
         default: cur_byte = SYNC_BYTE;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         PKT_IDLE: if (trigger) state_n = PKT_SEND;
         PKT_SEND: if (byte_done && byte_idx == LAST_BYTE) state_n = PKT_DONE;
         PKT_DONE: state_n = PKT_IDLE;
         default:  state_n = PKT_IDLE;
      endcase
   end

   // Tracks vsync even in reset, so a level already high at release is not
   // mistaken for an edge.
   always_ff @(posedge clk) begin
      vsync_q <= vsync;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= PKT_IDLE;
         byte_idx <= '0;
         x_q      <= '0;
         y_q      <= '0;
         sel_q    <= 1'b0;
      end else begin
         state <= state_n;
         if (trigger) begin
            x_q      <= xpos;
            y_q      <= ypos;
            sel_q    <= select;
            byte_idx <= '0;
         end else if (send_next) begin
            byte_idx <= byte_idx + 3'd1;
         end
      end
   end

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tx_byte (cur_byte),
      .tx      (tx),
      .done    (byte_done)
   );

endmodule

// File: tb/tb_tank_pos_tx.sv
module tb_tank_pos_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b0;
   logic [9:0] xpos = '0;
   logic [9:0] ypos = '0;
   logic       select = 1'b0;
   logic       tx, busy, packet_done;

   int total = 0;
   int bad = 0;

   tank_pos_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .vsync       (vsync),
      .xpos        (xpos),
      .ypos        (ypos),
      .select      (select),
      .tx          (tx),
      .busy        (busy),
      .packet_done (packet_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        sel;
      logic [39:0] pkt;   // {B4,B3,B2,B1,B0}
   } vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Called in the trigger cycle N. Checks every cycle N+1..N+200 against the
   // expected bit, then the done pulse at N+201 and idle at N+202.
   task automatic run_pkt(input string name, input logic [39:0] pkt,
                          input int chg_at, input int vs_at);
      int         c;
      logic [7:0] eb, got;
      logic       ferr, e;
      c = 0;
      for (int b = 0; b < 5; b++) begin
         eb   = pkt[8*b +: 8];
         got  = '0;
         ferr = 1'b0;
         for (int j = 0; j < 10; j++) begin
            e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : eb[j-1];
            for (int k = 0; k < CPB; k++) begin
               tick;
               c++;
               if (tx !== e || busy !== 1'b1 || packet_done !== 1'b0) ferr = 1'b1;
               if (k == 1 && j >= 1 && j <= 8) got[j-1] = tx;
               if (c == 3) vsync = 1'b0;
               if (c == vs_at) vsync = 1'b1;
               if (c == vs_at + 3) vsync = 1'b0;
               if (c == chg_at) begin
                  xpos = '0;
                  ypos = '0;
               end
            end
         end
         chk($sformatf("%s byte%0d {frame_err,byte}", name, b), {23'd0, ferr, got}, {24'd0, eb});
      end
      tick;
      chk({name, " N+201 {done,busy}"}, {30'd0, packet_done, busy}, 32'd3);
      tick;
      chk({name, " N+202 {done,busy,tx}"}, {29'd0, packet_done, busy, tx}, 32'd1);
   endtask

   task automatic fire;
      vsync = 1'b0;
      tick;
      vsync = 1'b1;
   endtask

   initial begin
      vec_t vecs [3];
      logic err;

      vecs[0] = '{x: 10'h155, y: 10'h2AA, sel: 1'b1, pkt: {8'h67, 8'h98, 8'hAA, 8'h55, 8'hA5}};
      vecs[1] = '{x: 10'h3FF, y: 10'h000, sel: 1'b0, pkt: {8'hCF, 8'h30, 8'h00, 8'hFF, 8'hA5}};
      vecs[2] = '{x: 10'h2C3, y: 10'h13C, sel: 1'b0, pkt: {8'hDB, 8'h24, 8'h3C, 8'hC3, 8'hA5}};

      // reset state
      rst = 1'b1;
      tick;
      tick;
      chk("reset {tx,busy,done}", {29'd0, tx, busy, packet_done}, 32'd4);
      rst = 1'b0;
      tick;
      chk("post-reset idle {tx,busy,done}", {29'd0, tx, busy, packet_done}, 32'd4);

      // table-driven packets
      for (int i = 0; i < 3; i++) begin
         xpos   = vecs[i].x;
         ypos   = vecs[i].y;
         select = vecs[i].sel;
         fire;
         run_pkt($sformatf("vec%0d", i), vecs[i].pkt, -1, -100);
      end

      // inputs change mid-packet: snapshot must hold
      xpos = 10'h155; ypos = 10'h2AA; select = 1'b1;
      fire;
      run_pkt("stable", vecs[0].pkt, 10, -100);

      // second rise while busy is dropped; a rise at N+210 starts at N+211
      xpos = 10'h155; ypos = 10'h2AA; select = 1'b1;
      fire;
      run_pkt("busy_drop", vecs[0].pkt, -1, 100);
      err = 1'b0;
      for (int c = 203; c <= 210; c++) begin
         tick;
         if (tx !== 1'b1 || busy !== 1'b0 || packet_done !== 1'b0) err = 1'b1;
      end
      chk("busy_drop no second packet", {31'd0, err}, 32'd0);
      vsync = 1'b1;
      run_pkt("retrigger", vecs[0].pkt, -1, -100);

      // reset mid-packet at N+60
      fire;
      for (int c = 1; c <= 60; c++) tick;
      rst = 1'b1;
      tick;
      chk("midreset {tx,busy,done}", {29'd0, tx, busy, packet_done}, 32'd4);
      rst = 1'b0;
      err = 1'b0;
      for (int c = 0; c < 250; c++) begin
         tick;
         if (tx !== 1'b1 || busy !== 1'b0 || packet_done !== 1'b0) err = 1'b1;
      end
      chk("midreset line stays idle", {31'd0, err}, 32'd0);

      // vsync level high across reset release: no packet
      vsync = 1'b1;
      rst = 1'b1;
      tick;
      tick;
      tick;
      rst = 1'b0;
      err = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick;
         if (tx !== 1'b1 || busy !== 1'b0) err = 1'b1;
      end
      chk("level vsync no trigger", {31'd0, err}, 32'd0);
      xpos = 10'h3FF; ypos = 10'h000; select = 1'b0;
      fire;
      run_pkt("after_level", vecs[1].pkt, -1, -100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
